// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - opcode constants, field positions and per-opcode operand usage
package core_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 6;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_SUB    = 4'h1,
        OP_ADD    = 4'h2,
        OP_ADDI   = 4'h3,
        OP_SHLLI  = 4'h4,
        OP_SHRLI  = 4'h5,
        OP_JUMP   = 4'h6,
        OP_JUMPL  = 4'h7,
        OP_JUMPG  = 4'h8,
        OP_JUMPE  = 4'h9,
        OP_JUMPNE = 4'hA,
        OP_CMP    = 4'hB,
        OP_LOAD   = 4'hC,
        OP_LOADI  = 4'hD,
        OP_STORE  = 4'hE,
        OP_MOV    = 4'hF
    } opcode_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } op_info_t;

    // Shared with Execute so both stages agree on which fields are live.
    function automatic op_info_t decode_op_info(input logic [3:0] opc);
        op_info_t info;
        info = '0;
        case (opc)
            OP_SUB, OP_ADD: begin
                info.uses_rs1  = 1'b1;
                info.uses_rs2  = 1'b1;
                info.writes_rd = 1'b1;
            end
            OP_CMP, OP_STORE: begin
                info.uses_rs1 = 1'b1;
                info.uses_rs2 = 1'b1;
            end
            OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOAD, OP_MOV: begin
                info.uses_rs1  = 1'b1;
                info.writes_rd = 1'b1;
            end
            OP_LOADI: info.writes_rd = 1'b1;
            default:  info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/writeback inputs and Execute-bound outputs of decode
interface decode_stage_if;
    logic [15:0] instr_in;
    logic [15:0] npc_in;
    logic        instr_valid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_index;
    logic [15:0] wb_data;
    logic [4:0]  control_out;
    logic [4:0]  dest_index_out;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [15:0] npc_out;
    logic [6:0]  immediate;
    logic        stall_out;

    modport master (
        output instr_in, npc_in, instr_valid, flush, wb_en, wb_index, wb_data,
        input  control_out, dest_index_out, reg1_data, reg2_data, npc_out, immediate, stall_out
    );

    modport slave (
        input  instr_in, npc_in, instr_valid, flush, wb_en, wb_index, wb_data,
        output control_out, dest_index_out, reg1_data, reg2_data, npc_out, immediate, stall_out
    );
endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 8x16 register file, two async read ports with write-first bypass
module decode_regfile
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [REG_IDX_W-1:0] i_wr_addr,
    input  logic [15:0]          i_wr_data,
    input  logic [REG_IDX_W-1:0] i_rd_addr_a,
    input  logic [REG_IDX_W-1:0] i_rd_addr_b,
    output logic [15:0]          o_rd_data_a,
    output logic [15:0]          o_rd_data_b
);
    logic [15:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // A consumer released on the writeback edge must see the value being written.
    assign o_rd_data_a = (i_wr_en && i_wr_addr == i_rd_addr_a) ? i_wr_data : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_wr_en && i_wr_addr == i_rd_addr_b) ? i_wr_data : r_regs[i_rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with RAW scoreboard interlock and output pipeline register
module decode_stage
    import core_pkg::*;
#(
    parameter int PEND_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    logic [3:0]           w_opcode;
    logic [REG_IDX_W-1:0] w_rd;
    logic [REG_IDX_W-1:0] w_rs1;
    logic [REG_IDX_W-1:0] w_rs2;
    logic [6:0]           w_imm;
    op_info_t             w_info;

    assign w_opcode = bus.instr_in[OPC_HI:OPC_LO];
    assign w_rd     = bus.instr_in[RD_HI:RD_LO];
    assign w_rs1    = bus.instr_in[RS1_HI:RS1_LO];
    assign w_rs2    = bus.instr_in[RS2_HI:RS2_LO];
    assign w_imm    = bus.instr_in[IMM_HI:IMM_LO];
    assign w_info   = decode_op_info(w_opcode);

    logic [PEND_DEPTH-1:0] r_pend_valid;
    logic [REG_IDX_W-1:0]  r_pend_rd [PEND_DEPTH];
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;
    logic                  w_hazard;
    logic                  w_issue;

    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (r_pend_valid[i]) begin
                if (r_pend_rd[i] == w_rs1) w_rs1_hit = 1'b1;
                if (r_pend_rd[i] == w_rs2) w_rs2_hit = 1'b1;
            end
        end
    end

    assign w_hazard = bus.instr_valid &
                      ((w_info.uses_rs1 & w_rs1_hit) | (w_info.uses_rs2 & w_rs2_hit));
    assign w_issue  = bus.instr_valid & ~bus.flush & ~w_hazard;

    // Flush does not clear older entries: their writes are still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                r_pend_valid[i] <= 1'b0;
                r_pend_rd[i]    <= '0;
            end
        end else begin
            r_pend_valid[0] <= w_issue & w_info.writes_rd;
            r_pend_rd[0]    <= w_rd;
            for (int i = 1; i < PEND_DEPTH; i++) begin
                r_pend_valid[i] <= r_pend_valid[i-1];
                r_pend_rd[i]    <= r_pend_rd[i-1];
            end
        end
    end

    logic                 w_wb_write;
    logic [15:0]          w_rs1_data;
    logic [15:0]          w_rs2_data;

    assign w_wb_write = bus.wb_en & (bus.wb_index[4:3] == 2'b00);

    decode_regfile u_regfile (
        .clk         (clk),
        .rst         (reset),
        .i_wr_en     (w_wb_write),
        .i_wr_addr   (bus.wb_index[2:0]),
        .i_wr_data   (bus.wb_data),
        .i_rd_addr_a (w_rs1),
        .i_rd_addr_b (w_rs2),
        .o_rd_data_a (w_rs1_data),
        .o_rd_data_b (w_rs2_data)
    );

    logic [4:0]  r_control;
    logic [4:0]  r_dest;
    logic [15:0] r_reg1;
    logic [15:0] r_reg2;
    logic [15:0] r_npc;
    logic [6:0]  r_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_control <= '0;
            r_dest    <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_npc     <= '0;
            r_imm     <= '0;
        end else if (w_issue) begin
            r_control <= {1'b0, w_opcode};
            r_dest    <= {2'b00, w_rd};
            r_reg1    <= w_rs1_data;
            r_reg2    <= w_rs2_data;
            r_npc     <= bus.npc_in;
            r_imm     <= w_imm;
        end else begin
            r_control <= '0;
            r_dest    <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_npc     <= '0;
            r_imm     <= '0;
        end
    end

    assign bus.control_out    = r_control;
    assign bus.dest_index_out = r_dest;
    assign bus.reg1_data      = r_reg1;
    assign bus.reg2_data      = r_reg2;
    assign bus.npc_out        = r_npc;
    assign bus.immediate      = r_imm;
    assign bus.stall_out      = w_hazard & ~bus.flush & ~reset;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with reference model
module tb_decode_stage;
    localparam int PEND_DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage #(.PEND_DEPTH(PEND_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  ctl;
        logic [4:0]  dest;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] npc;
        logic [6:0]  imm;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          stall_cycles = 0;
    logic [15:0] m_rf [8];
    int          m_pend[$];

    function automatic bit m_uses_rs1(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'hB, 4'hE, 4'h3, 4'h4, 4'h5, 4'hC, 4'hF};
    endfunction

    function automatic bit m_uses_rs2(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'hB, 4'hE};
    endfunction

    function automatic bit m_writes(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hC, 4'hD, 4'hF};
    endfunction

    function automatic bit m_pending(input int r);
        foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        bus.instr_in    = '0;
        bus.npc_in      = '0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_index    = '0;
        bus.wb_data     = '0;
    endtask

    task automatic step(input bit v, input logic [15:0] ins, input logic [15:0] npc,
                        input bit fl, input bit we, input logic [4:0] wi, input logic [15:0] wd);
        logic [3:0] op;
        int rd, rs1, rs2;
        bit haz, issue, wr_ok;
        exp_t e;
        @(negedge clk);
        bus.instr_in = ins; bus.npc_in = npc; bus.instr_valid = v; bus.flush = fl;
        bus.wb_en = we; bus.wb_index = wi; bus.wb_data = wd;
        #1;
        op  = ins[15:12];
        rd  = int'(ins[11:9]);
        rs1 = int'(ins[8:6]);
        rs2 = int'(ins[5:3]);
        haz = v && ((m_uses_rs1(op) && m_pending(rs1)) || (m_uses_rs2(op) && m_pending(rs2)));
        tests++;
        if (bus.stall_out !== (haz && !fl)) begin
            fails++;
            $display("FAIL stall_out: got %b expected %b (instr %h)", bus.stall_out, haz && !fl, ins);
        end
        if (bus.stall_out === 1'b1) stall_cycles++;
        wr_ok = we && (wi[4:3] == 2'b00);
        issue = v && !fl && !haz;
        if (issue) begin
            e.ctl  = {1'b0, op};
            e.dest = {2'b00, ins[11:9]};
            e.r1   = (wr_ok && int'(wi[2:0]) == rs1) ? wd : m_rf[rs1];
            e.r2   = (wr_ok && int'(wi[2:0]) == rs2) ? wd : m_rf[rs2];
            e.npc  = npc;
            e.imm  = ins[6:0];
        end else begin
            e = '{5'd0, 5'd0, 16'd0, 16'd0, 16'd0, 7'd0};
        end
        exp_q.push_back(e);
        if (wr_ok) m_rf[wi[2:0]] = wd;
        m_pend.push_front((issue && m_writes(op)) ? rd : -1);
        void'(m_pend.pop_back());
    endtask

    task automatic do_reset(input bit keep_inputs);
        @(negedge clk);
        if (!keep_inputs) drive_idle();
        reset = 1'b1;
        #1;
        tests++;
        if (bus.control_out !== 0 || bus.dest_index_out !== 0 || bus.reg1_data !== 0 ||
            bus.reg2_data !== 0 || bus.npc_out !== 0 || bus.immediate !== 0 || bus.stall_out !== 0) begin
            fails++;
            $display("FAIL reset_outputs: got ctl=%h dest=%h r1=%h r2=%h npc=%h imm=%h stall=%b expected all 0",
                     bus.control_out, bus.dest_index_out, bus.reg1_data, bus.reg2_data,
                     bus.npc_out, bus.immediate, bus.stall_out);
        end
        drive_idle();
        exp_q.delete();
        foreach (m_rf[i]) m_rf[i] = '0;
        m_pend.delete();
        for (int i = 0; i < PEND_DEPTH; i++) m_pend.push_back(-1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.control_out !== e.ctl || bus.dest_index_out !== e.dest ||
                    bus.reg1_data !== e.r1 || bus.reg2_data !== e.r2 ||
                    bus.npc_out !== e.npc || bus.immediate !== e.imm) begin
                    fails++;
                    $display("FAIL bundle: got ctl=%h dest=%h r1=%h r2=%h npc=%h imm=%h expected ctl=%h dest=%h r1=%h r2=%h npc=%h imm=%h",
                             bus.control_out, bus.dest_index_out, bus.reg1_data, bus.reg2_data,
                             bus.npc_out, bus.immediate, e.ctl, e.dest, e.r1, e.r2, e.npc, e.imm);
                end
            end
        end
    end

    initial begin : stimulus
        drive_idle();
        do_reset(1'b0);

        // R5 written, then reset clears it; MOV R1,R5 reads 0
        step(0, 16'h0000, 16'h0000, 0, 1, 5'd5, 16'h1234);
        step(1, 16'hF340, 16'h0021, 0, 0, 5'd0, 16'h0000);
        do_reset(1'b0);
        step(1, 16'hF340, 16'h0022, 0, 0, 5'd0, 16'h0000);

        // ADD R3,R1,R2 after writeback of R1=10, R2=3
        step(0, 16'h0000, 16'h0000, 0, 1, 5'd1, 16'd10);
        step(0, 16'h0000, 16'h0000, 0, 1, 5'd2, 16'd3);
        step(0, 16'h0000, 16'h0000, 0, 0, 5'd0, 16'h0000);
        step(0, 16'h0000, 16'h0000, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2650, 16'h0031, 0, 0, 5'd0, 16'h0000);

        // ADDI R1,R0,5 then dependent ADD R2,R1,R1 stalls two cycles
        stall_cycles = 0;
        step(1, 16'h3205, 16'h0040, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0041, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0041, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0041, 0, 1, 5'd1, 16'd5);
        tests++;
        if (stall_cycles != 2) begin
            fails++;
            $display("FAIL raw_stall_len: got %0d cycles expected 2", stall_cycles);
        end

        // Bypass on MOV R6,R4; out-of-range writeback index ignored
        step(1, 16'hFD00, 16'h0050, 0, 1, 5'd4, 16'hBEEF);
        step(0, 16'h0000, 16'h0000, 0, 1, 5'h0C, 16'hDEAD);
        step(1, 16'hFD00, 16'h0052, 0, 0, 5'd0, 16'h0000);

        // Flush together with a hazard
        step(1, 16'h3205, 16'h0060, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0061, 1, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0062, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0062, 0, 0, 5'd0, 16'h0000);

        // JUMPE with rs bits matching a pending LOADI R7 does not stall
        step(1, 16'hDE00, 16'h000F, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h91FF, 16'h0010, 0, 0, 5'd0, 16'h0000);

        // Reset asserted mid-stall
        step(1, 16'h3205, 16'h0070, 0, 0, 5'd0, 16'h0000);
        step(1, 16'h2448, 16'h0071, 0, 0, 5'd0, 16'h0000);
        do_reset(1'b1);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)), 16'($urandom));
        end

        step(0, 16'h0000, 16'h0000, 0, 0, 5'd0, 16'h0000);
        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
